// File: rtl/aib_pkg.sv
// Shared constants and helpers for the bonded AIB channel adapter.
// Defaults match a 4 x 72-bit bonded link with 8-deep rx deskew buffering.
package aib_pkg;

   localparam int AIB_NUM_CHN         = 4;
   localparam int AIB_DATA_W          = 72;
   localparam int AIB_BOND_FIFO_DEPTH = 8;

   // LSB position of lane 'lane' inside a bonded word of per-lane width 'width'.
   function automatic int lane_lsb(input int lane, input int width);
      return lane * width;
   endfunction

endpackage

// File: rtl/aib_sync_fifo.sv
// First-word-fall-through FIFO: a push in cycle t is at the head in t+1; head reads 0 when empty.
// Pushes while full and pops while empty are ignored; i_flush empties it and wins over push/pop.
module aib_sync_fifo #(
   parameter int WIDTH = 72,
   parameter int DEPTH = 8
) (
   input  logic             i_bus_clk,
   input  logic             i_rst_n,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_pop_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign o_full     = (count_q == CW'(DEPTH));
   assign o_empty    = (count_q == '0);
   assign do_push    = i_push & ~o_full & ~i_flush;
   assign do_pop     = i_pop & ~o_empty & ~i_flush;
   assign o_pop_data = o_empty ? '0 : mem_q[rd_ptr_q];

   // DEPTH is a power of two, so the pointers wrap by natural overflow.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (i_flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         if (do_push && !do_pop)      count_d = count_q + CW'(1);
         else if (!do_push && do_pop) count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge i_bus_clk) begin
      if (!i_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge i_bus_clk) begin
      if (do_push) mem_q[wr_ptr_q] <= i_push_data;
   end

endmodule

// File: rtl/aib_chn_bond.sv
// Bonds NUM_CHN AIB channels: tx eagerly forks one wide word (0 latency), rx deskews lanes (1 cycle).
// Wide tx ready waits for every enabled lane; per-lane rx ready drops only when that lane's FIFO is full.
module aib_chn_bond
   import aib_pkg::*;
#(
   parameter int NUM_CHN    = AIB_NUM_CHN,
   parameter int DATA_W     = AIB_DATA_W,
   parameter int FIFO_DEPTH = AIB_BOND_FIFO_DEPTH
) (
   input  logic                        i_bus_clk,
   input  logic                        i_rst_n,
   input  logic [NUM_CHN-1:0]          c_chn_en,
   input  logic                        i_flush,
   input  logic                        i_tx_valid,
   output logic                        o_tx_ready,
   input  logic [NUM_CHN*DATA_W-1:0]   i_tx_data,
   output logic [NUM_CHN-1:0]          o_chn_tx_valid,
   input  logic [NUM_CHN-1:0]          i_chn_tx_ready,
   output logic [NUM_CHN*DATA_W-1:0]   o_chn_tx_data,
   input  logic [NUM_CHN-1:0]          i_chn_rx_valid,
   output logic [NUM_CHN-1:0]          o_chn_rx_ready,
   input  logic [NUM_CHN*DATA_W-1:0]   i_chn_rx_data,
   output logic                        o_rx_valid,
   input  logic                        i_rx_ready,
   output logic [NUM_CHN*DATA_W-1:0]   o_rx_data,
   output logic                        o_skew_err
);

   logic [NUM_CHN-1:0] done_q, done_d;
   logic [NUM_CHN-1:0] fifo_full, fifo_empty, fifo_push;
   logic               pop_all;
   logic               skew_cond;
   logic               skew_q, skew_d;

   // done[k] marks lanes of the current word already handed to their channel.
   assign o_chn_tx_valid = {NUM_CHN{i_tx_valid}} & c_chn_en & ~done_q;
   assign o_tx_ready     = &(~c_chn_en | done_q | i_chn_tx_ready);

   always_comb begin
      done_d = done_q | (o_chn_tx_valid & i_chn_tx_ready);
      if (i_flush || (i_tx_valid && o_tx_ready)) done_d = '0;
   end

   assign o_chn_rx_ready = ~fifo_full | ~c_chn_en;
   assign fifo_push      = i_chn_rx_valid & c_chn_en & ~fifo_full;
   assign o_rx_valid     = (|c_chn_en) & ~(|(c_chn_en & fifo_empty));
   assign pop_all        = o_rx_valid & i_rx_ready;

   // One lane starved while another is saturated can never resolve on its own.
   assign skew_cond = (|(c_chn_en & fifo_full)) & (|(c_chn_en & fifo_empty));
   assign skew_d    = i_flush ? 1'b0 : (skew_q | skew_cond);
   assign o_skew_err = skew_q;

   for (genvar k = 0; k < NUM_CHN; k++) begin : gen_lane
      localparam int LSB = lane_lsb(k, DATA_W);
      logic [DATA_W-1:0] head;

      assign o_chn_tx_data[LSB +: DATA_W] = c_chn_en[k] ? i_tx_data[LSB +: DATA_W] : '0;
      assign o_rx_data[LSB +: DATA_W]     = c_chn_en[k] ? head : '0;

      aib_sync_fifo #(
         .WIDTH (DATA_W),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .i_bus_clk   (i_bus_clk),
         .i_rst_n     (i_rst_n),
         .i_flush     (i_flush),
         .i_push      (fifo_push[k]),
         .i_push_data (i_chn_rx_data[LSB +: DATA_W]),
         .i_pop       (pop_all & c_chn_en[k]),
         .o_pop_data  (head),
         .o_full      (fifo_full[k]),
         .o_empty     (fifo_empty[k])
      );
   end

   always_ff @(posedge i_bus_clk) begin
      if (!i_rst_n) begin
         done_q <= '0;
         skew_q <= 1'b0;
      end else begin
         done_q <= done_d;
         skew_q <= skew_d;
      end
   end

endmodule

// File: tb/tb_aib_chn_bond.sv
// Directed bench for aib_chn_bond: combinational tx fork vectors from a table,
// plus sequences for partial tx handshakes, rx deskew, masking, skew error, flush and reset.
module tb_aib_chn_bond;

   localparam int N   = 4;
   localparam int W   = 72;
   localparam int TOT = N * W;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   en;
   logic           flush;
   logic           tx_valid;
   logic           tx_ready;
   logic [TOT-1:0] tx_data;
   logic [N-1:0]   chn_tx_valid;
   logic [N-1:0]   chn_tx_ready;
   logic [TOT-1:0] chn_tx_data;
   logic [N-1:0]   chn_rx_valid;
   logic [N-1:0]   chn_rx_ready;
   logic [TOT-1:0] chn_rx_data;
   logic           rx_valid;
   logic           rx_ready;
   logic [TOT-1:0] rx_data;
   logic           skew_err;

   int nchk = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   aib_chn_bond #(.NUM_CHN(N), .DATA_W(W), .FIFO_DEPTH(8)) dut (
      .i_bus_clk      (clk),
      .i_rst_n        (rst_n),
      .c_chn_en       (en),
      .i_flush        (flush),
      .i_tx_valid     (tx_valid),
      .o_tx_ready     (tx_ready),
      .i_tx_data      (tx_data),
      .o_chn_tx_valid (chn_tx_valid),
      .i_chn_tx_ready (chn_tx_ready),
      .o_chn_tx_data  (chn_tx_data),
      .i_chn_rx_valid (chn_rx_valid),
      .o_chn_rx_ready (chn_rx_ready),
      .i_chn_rx_data  (chn_rx_data),
      .o_rx_valid     (rx_valid),
      .i_rx_ready     (rx_ready),
      .o_rx_data      (rx_data),
      .o_skew_err     (skew_err)
   );

   // Lane k of word 'tag' = {56'hAA.., tag, k}.
   function automatic logic [TOT-1:0] mkw(input logic [7:0] tag);
      logic [TOT-1:0] w;
      for (int k = 0; k < N; k++) w[k*W +: W] = {56'hAAAA_AAAA_AAAA_AA, tag, 8'(k)};
      return w;
   endfunction

   function automatic logic [TOT-1:0] mask(input logic [TOT-1:0] w, input logic [N-1:0] m);
      logic [TOT-1:0] r;
      r = '0;
      for (int k = 0; k < N; k++) if (m[k]) r[k*W +: W] = w[k*W +: W];
      return r;
   endfunction

   task automatic chk(input string name, input logic [TOT-1:0] act, input logic [TOT-1:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [N-1:0] en;
      logic         v;
      logic [N-1:0] rdy;
      logic [7:0]   tag;
      logic         exp_tx_rdy;
      logic [N-1:0] exp_cv;
   } vec_t;

   vec_t vt[8];

   initial begin
      int first;
      int got;
      logic [TOT-1:0] w;
      logic [N-1:0]   exp_v [4];
      logic           exp_r [4];
      logic [N-1:0]   rdy_seq [4];
      int             vcnt [N];
      int             rcnt;

      vt[0] = '{4'hF, 1'b1, 4'hF, 8'hA0, 1'b1, 4'hF};
      vt[1] = '{4'hF, 1'b0, 4'hF, 8'hA1, 1'b1, 4'h0};
      vt[2] = '{4'hF, 1'b0, 4'hB, 8'hA2, 1'b0, 4'h0};
      vt[3] = '{4'h5, 1'b1, 4'h5, 8'hA3, 1'b1, 4'h5};
      vt[4] = '{4'h0, 1'b1, 4'h0, 8'hA4, 1'b1, 4'h0};
      vt[5] = '{4'hA, 1'b0, 4'h5, 8'hA5, 1'b0, 4'h0};
      vt[6] = '{4'hA, 1'b1, 4'hA, 8'hA6, 1'b1, 4'hA};
      vt[7] = '{4'h1, 1'b1, 4'h1, 8'hA7, 1'b1, 4'h1};

      rst_n = 1'b0; en = 4'hF; flush = 1'b0;
      tx_valid = 1'b0; tx_data = '0; chn_tx_ready = 4'hF;
      chn_rx_valid = '0; chn_rx_data = '0; rx_ready = 1'b0;
      repeat (2) next_cycle();
      rst_n = 1'b1;

      // Reset state
      @(negedge clk);
      chk("rst_rx_valid", TOT'(rx_valid), '0);
      chk("rst_skew", TOT'(skew_err), '0);
      chk("rst_rx_data", rx_data, '0);
      chk("rst_chn_tx_valid", TOT'(chn_tx_valid), '0);
      chk("rst_chn_rx_ready", TOT'(chn_rx_ready), TOT'(4'hF));
      chk("rst_tx_ready", TOT'(tx_ready), TOT'(1'b1));
      next_cycle();

      // Combinational fork table
      for (int i = 0; i < 8; i++) begin
         en = vt[i].en; tx_valid = vt[i].v; chn_tx_ready = vt[i].rdy;
         tx_data = mkw(vt[i].tag);
         @(negedge clk);
         chk($sformatf("vec%0d_tx_ready", i), TOT'(tx_ready), TOT'(vt[i].exp_tx_rdy));
         chk($sformatf("vec%0d_chn_tx_valid", i), TOT'(chn_tx_valid), TOT'(vt[i].exp_cv));
         chk($sformatf("vec%0d_chn_tx_data", i), chn_tx_data, mask(mkw(vt[i].tag), vt[i].en));
         chk($sformatf("vec%0d_chn_rx_ready", i), TOT'(chn_rx_ready), TOT'(4'hF));
         next_cycle();
      end

      // Lane 2 stalled 3 cycles
      en = 4'hF; tx_valid = 1'b1; tx_data = mkw(8'hB0);
      rdy_seq = '{4'hB, 4'hB, 4'hB, 4'hF};
      exp_v   = '{4'hF, 4'h4, 4'h4, 4'h4};
      exp_r   = '{1'b0, 1'b0, 1'b0, 1'b1};
      for (int k = 0; k < N; k++) vcnt[k] = 0;
      rcnt = 0;
      for (int c = 0; c < 4; c++) begin
         chn_tx_ready = rdy_seq[c];
         @(negedge clk);
         chk($sformatf("stall_c%0d_chn_tx_valid", c), TOT'(chn_tx_valid), TOT'(exp_v[c]));
         chk($sformatf("stall_c%0d_tx_ready", c), TOT'(tx_ready), TOT'(exp_r[c]));
         for (int k = 0; k < N; k++) if (chn_tx_valid[k]) vcnt[k]++;
         if (tx_ready) rcnt++;
         next_cycle();
      end
      tx_valid = 1'b0;
      chk("stall_lane0_cycles", TOT'(vcnt[0]), TOT'(1));
      chk("stall_lane2_cycles", TOT'(vcnt[2]), TOT'(4));
      chk("stall_lane3_cycles", TOT'(vcnt[3]), TOT'(1));
      chk("stall_ready_cycles", TOT'(rcnt), TOT'(1));
      tx_valid = 1'b1; chn_tx_ready = 4'h0; tx_data = mkw(8'hB1);
      @(negedge clk);
      chk("stall_done_cleared", TOT'(chn_tx_valid), TOT'(4'hF));
      next_cycle();
      tx_valid = 1'b0; chn_tx_ready = 4'hF;

      // Rx deskew: lane 3 lags 5 cycles, 8 words
      rx_ready = 1'b1; first = -1; got = 0;
      for (int c = 0; c < 16; c++) begin
         chn_rx_valid = '0;
         chn_rx_data  = '0;
         if (c < 8) begin
            w = mkw(8'(c));
            chn_rx_valid[2:0] = 3'b111;
            chn_rx_data[3*W-1:0] = w[3*W-1:0];
         end
         if (c >= 5 && c < 13) begin
            w = mkw(8'(c - 5));
            chn_rx_valid[3] = 1'b1;
            chn_rx_data[3*W +: W] = w[3*W +: W];
         end
         @(negedge clk);
         if (rx_valid) begin
            if (first < 0) first = c;
            chk($sformatf("deskew_word%0d", got), rx_data, mkw(8'(got)));
            got++;
         end
         next_cycle();
      end
      chn_rx_valid = '0; rx_ready = 1'b0;
      chk("deskew_first_valid_cycle", TOT'(first), TOT'(6));
      chk("deskew_word_count", TOT'(got), TOT'(8));

      // Mask 0101
      en = 4'h5; chn_rx_valid = 4'hF; chn_rx_data = mkw(8'hC0);
      @(negedge clk);
      chk("mask_chn_rx_ready", TOT'(chn_rx_ready), TOT'(4'hF));
      next_cycle();
      chn_rx_valid = '0; rx_ready = 1'b1;
      @(negedge clk);
      chk("mask_rx_valid", TOT'(rx_valid), TOT'(1'b1));
      chk("mask_rx_data", rx_data, mask(mkw(8'hC0), 4'h5));
      next_cycle();
      @(negedge clk);
      chk("mask_rx_popped", TOT'(rx_valid), '0);
      next_cycle();
      rx_ready = 1'b0; en = 4'hF;

      // Skew error: lane 0 fills, lane 1.. never push
      for (int c = 0; c < 8; c++) begin
         chn_rx_valid = 4'h1; chn_rx_data = mkw(8'(8'hD0 + c));
         @(negedge clk);
         if (c == 0 || c == 7) chk($sformatf("skew_ready0_c%0d", c), TOT'(chn_rx_ready[0]), TOT'(1'b1));
         next_cycle();
      end
      chn_rx_valid = '0;
      @(negedge clk);
      chk("skew_full_ready", TOT'(chn_rx_ready), TOT'(4'hE));
      chk("skew_not_yet", TOT'(skew_err), '0);
      next_cycle();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("skew_sticky%0d", c), TOT'(skew_err), TOT'(1'b1));
         next_cycle();
      end
      flush = 1'b1;
      next_cycle();
      flush = 1'b0;
      @(negedge clk);
      chk("flush_skew", TOT'(skew_err), '0);
      chk("flush_rx_ready", TOT'(chn_rx_ready), TOT'(4'hF));
      chk("flush_rx_valid", TOT'(rx_valid), '0);
      chn_rx_valid = 4'hF; chn_rx_data = mkw(8'h77);
      next_cycle();
      chn_rx_valid = '0; rx_ready = 1'b1;
      @(negedge clk);
      chk("flush_new_word", rx_data, mkw(8'h77));
      next_cycle();
      rx_ready = 1'b0;

      // Reset with partial tx word and 3 buffered rx words
      for (int c = 0; c < 3; c++) begin
         chn_rx_valid = 4'hF; chn_rx_data = mkw(8'(8'hE0 + c));
         next_cycle();
      end
      chn_rx_valid = '0;
      tx_valid = 1'b1; tx_data = mkw(8'hF0); chn_tx_ready = 4'h3;
      @(negedge clk);
      chk("rstx_pre_valid", TOT'(rx_valid), TOT'(1'b1));
      next_cycle();
      chn_tx_ready = 4'h0; rst_n = 1'b0;
      @(negedge clk);
      chk("rstx_partial", TOT'(chn_tx_valid), TOT'(4'hC));
      next_cycle();
      rst_n = 1'b1;
      @(negedge clk);
      chk("rstx_done_cleared", TOT'(chn_tx_valid), TOT'(4'hF));
      chk("rstx_rx_valid", TOT'(rx_valid), '0);
      chk("rstx_rx_data", rx_data, '0);
      tx_valid = 1'b0;
      chn_rx_valid = 4'hF; chn_rx_data = mkw(8'h55);
      next_cycle();
      chn_rx_valid = '0;
      @(negedge clk);
      chk("rstx_fresh_head", rx_data, mkw(8'h55));
      next_cycle();

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule

// File: doc/aib_chn_bond.md
# aib_chn_bond

Multi-channel bonding adapter. On transmit it splits one wide ready/valid word into NUM_CHN per-channel lanes. On receive it re-aligns the per-channel lanes into one wide word. It sits between the bus-side fabric and NUM_CHN instances of the single AIB channel, on the bus clock. It generalises the single 72-bit channel to a parametrised, maskable bonded link that absorbs inter-channel skew.

## Interface
Parameters:
- NUM_CHN, 4: number of bonded channels (1..16)
- DATA_W, 72: per-channel payload width
- FIFO_DEPTH, 8: per-channel rx deskew FIFO depth (power of two, ≥2)

Ports:
- i_bus_clk  in  1  bus clock; the only clock
- i_rst_n  in  1  reset, synchronous, active-low
- c_chn_en  in  NUM_CHN  channel enable mask; static except while idle
- i_flush  in  1  synchronous clear of FIFOs, fork flags and error
- i_tx_valid  in  1  wide tx word valid
- o_tx_ready  out  1  wide tx word accepted
- i_tx_data  in  NUM_CHN*DATA_W  lane k = bits [k*DATA_W +: DATA_W]
- o_chn_tx_valid  out  NUM_CHN  per-channel tx valid
- i_chn_tx_ready  in  NUM_CHN  per-channel tx ready
- o_chn_tx_data  out  NUM_CHN*DATA_W  per-channel tx payload
- i_chn_rx_valid  in  NUM_CHN  per-channel rx valid
- o_chn_rx_ready  out  NUM_CHN  per-channel rx ready
- i_chn_rx_data  in  NUM_CHN*DATA_W  per-channel rx payload
- o_rx_valid  out  1  wide rx word valid
- i_rx_ready  in  1  wide rx consumer ready
- o_rx_data  out  NUM_CHN*DATA_W  wide rx word
- o_skew_err  out  1  sticky deskew deadlock flag

## Operation
TX eager fork:
- done[k] is a registered flag per channel. It is 1 when lane k of the current word has already been taken.
- o_chn_tx_valid[k] = i_tx_valid & c_chn_en[k] & ~done[k].
- o_chn_tx_data lane k = i_tx_data lane k when c_chn_en[k], else 0.
- o_tx_ready = AND over k of (~c_chn_en[k] | done[k] | i_chn_tx_ready[k]).
- When i_tx_valid & o_tx_ready, all done[k] clear to 0.
- Otherwise, done[k] sets on a lane handshake (o_chn_tx_valid[k] & i_chn_tx_ready[k]).
- Each lane of a word is transferred exactly once. Lanes may complete in different cycles.
- All lanes disabled: o_tx_ready = 1 and the word is discarded.

RX deskew:
- Each channel has one first-word-fall-through FIFO of FIFO_DEPTH entries.
- o_chn_rx_ready[k] = ~full[k] | ~c_chn_en[k]. Data arriving on a disabled channel is dropped.
- Push on channel k when i_chn_rx_valid[k] & o_chn_rx_ready[k] & c_chn_en[k].
- o_rx_valid = (any enabled) & AND over enabled k of ~empty[k].
- o_rx_data lane k = FIFO k head when enabled, else 0.
- On o_rx_valid & i_rx_ready, every enabled FIFO pops together.
- Ready is derived from full only: a full FIFO does not accept a push even in a pop cycle.

Skew error:
- o_skew_err sets when some enabled FIFO is full while another enabled FIFO is empty. In that state the link cannot make progress.
- Once set, it holds until reset or i_flush.

i_flush:
- Same effect as reset on all state (FIFO pointers and counts, done flags, o_skew_err) in the cycle it is sampled.
- Same-cycle pushes and pops are ignored.

## Timing
- Reset values: done=0 and all FIFOs empty.
- Resulting outputs after reset: o_rx_valid=0, o_skew_err=0, o_rx_data=0, o_chn_tx_valid=0.
- Resulting outputs after reset: o_chn_rx_ready=all 1, o_tx_ready = AND over k of (~c_chn_en[k] | i_chn_tx_ready[k]).
- TX latency is 0 (combinational fork). Paths i_chn_tx_ready→o_tx_ready and i_tx_valid→o_chn_tx_valid are combinational.
- RX latency: a word pushed in cycle t is visible at the FIFO head in cycle t+1. o_rx_valid rises in the cycle after the last enabled lane is pushed.
- Each FIFO holds a registered count of width $clog2(FIFO_DEPTH+1). Read and write pointers wrap modulo FIFO_DEPTH.
- Within one FIFO, a push and a pop in the same cycle leave the count unchanged.
- Reset mid-transfer discards any partial tx word (done cleared) and all buffered rx data.
- o_skew_err updates one cycle after the full/empty condition is registered.

## Structure
- Package aib_pkg holds:
  - default constants AIB_NUM_CHN=4, AIB_DATA_W=72, AIB_BOND_FIFO_DEPTH=8
  - a lane-index helper function
- Sub-module aib_sync_fifo:
  - parametrised on width and depth, FWFT
  - ports: i_bus_clk, i_rst_n, i_flush, push/pop, full/empty
  - instantiated NUM_CHN times in a generate loop
- Fork logic and skew detector stay in the top module.

## Test plan
- All 4 lanes ready, send 0xA…A0..A3 -> o_tx_ready=1 same cycle, each lane carries its slice, done stays 0.
- Lane 2 ready held low for 3 cycles -> lanes 0,1,3 each valid for exactly 1 cycle. Lane 2 valid for 4 cycles. o_tx_ready high only in cycle 4. No lane repeated.
- Rx lane 3 delayed 5 cycles relative to lanes 0–2 -> o_rx_valid first rises the cycle after the lane-3 push. Wide word equals pushed slices in order; 8 back-to-back words emerge unreordered.
- c_chn_en=4'b0101 -> lanes 1,3 tx valid=0 and rx ready=1. o_rx_data lanes 1,3 = 0. Words complete on lanes 0,2 only.
- Lane 0 sends 8 words, lane 1 sends none -> lane 0 ready drops after the 8th push. o_skew_err=1 and stays 1. i_flush pulse -> o_skew_err=0, all FIFOs empty.
- Reset asserted with a partial tx word and 3 buffered rx words -> next cycle done=0, o_rx_valid=0, FIFO counts=0.
